// File: rtl/riscv_pkg.sv
// Purpose: shared register-file addressing types for decode, hazard unit and register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   REG_AW     architectural register address width of the RV32I core
//   reg_addr_t register index type
//   ZERO_REG   the hardwired-zero register x0
package riscv_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Purpose: per-register busy bits tracking in-flight producers for hazard stalls.
// Latency: busy_vec updates on the clock edge after issue/writeback/flush.
// Backpressure: none; it only reports state, and the hazard unit stalls decode.
//   clk, reset            clock and asynchronous active-high reset
//   issue_vld, issue_rd   decode issues a producer of issue_rd (sets busy)
//   we, wr_addr           writeback completes for wr_addr (clears busy)
//   flush                 drop all in-flight producers except a same-cycle issue
//   busy_vec              current busy bits, bit 0 is always 0
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 2 ** REG_AW,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_vld,
    input  logic [AW-1:0]       issue_rd,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Priority per register: a new issue always wins (it is the newest
    // producer, even against a same-cycle writeback or flush); otherwise
    // flush clears, then writeback clears, else hold.
    always_comb begin
        busy_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_vld && (issue_rd == AW'(r)))
                busy_nxt[r] = 1'b1;
            else if (flush)
                busy_nxt[r] = 1'b0;
            else if (we && (wr_addr == AW'(r)))
                busy_nxt[r] = 1'b0;
            else
                busy_nxt[r] = busy_vec[r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_vec <= '0;
        else
            busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/pipe_reg_file.sv
// Purpose: pipelined integer register file with N bypassed read ports and a busy scoreboard.
// Latency: reads are combinational (zero cycles); writes land in the array on the next edge.
// Backpressure: none accepted; rs_stall tells the hazard unit when a source is not yet available.
//   clk, reset         clock and asynchronous active-high reset
//   rs_addr/rs_data    NUM_READ packed read ports (port i at [i*AW +: AW] / [i*WIDTH +: WIDTH])
//   rs_stall           per-port: source busy and not satisfied by the writeback bypass
//   we/wr_addr/wr_data writeback port
//   issue_vld/issue_rd decode issue of a destination register
//   flush              clear all busy bits (branch redirect)
//   dbg_addr/dbg_data  debug read of the array, no bypass
//   busy_vec           scoreboard state
module pipe_reg_file
    import riscv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 2 ** REG_AW,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_READ*AW-1:0]    rs_addr,
    output logic [NUM_READ*WIDTH-1:0] rs_data,
    output logic [NUM_READ-1:0]       rs_stall,
    input  logic                      we,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      issue_vld,
    input  logic [AW-1:0]             issue_rd,
    input  logic                      flush,
    input  logic [AW-1:0]             dbg_addr,
    output logic [WIDTH-1:0]          dbg_data,
    output logic [NUM_REGS-1:0]       busy_vec
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regs [NUM_REGS];

    // Register 0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .we        (we),
        .wr_addr   (wr_addr),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    // Forwarding is held off while in reset so every read output is zero
    // during reset, matching the cleared array.
    logic wb_fwd;
    assign wb_fwd = BYP_EN && we && !reset;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = rs_addr[i*AW +: AW];
        assign is_zero = (addr == '0);
        assign hit     = wb_fwd && (wr_addr == addr);

        assign rs_data[i*WIDTH +: WIDTH] = is_zero ? '0 :
                                           hit     ? wr_data :
                                                     regs[addr];
        assign rs_stall[i] = busy_vec[addr] && !hit && !is_zero;
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_pipe_reg_file.sv
// Purpose: directed self-checking bench for pipe_reg_file across three configurations.
// Latency: checks combinational reads 1ns after inputs change, registered state after the edge.
// Backpressure: n/a.
//   dut_a: 32 regs, 2 read ports, bypass on
//   dut_b: 16 regs, 1 read port,  bypass off
//   dut_c: 16 regs, 4 read ports, bypass on
module tb_pipe_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  dbg_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;

    logic [63:0]  rs_data_a;
    logic [1:0]   stall_a;
    logic [31:0]  dbg_a;
    logic [31:0]  busy_a;

    logic [31:0]  rs_data_b;
    logic [0:0]   stall_b;
    logic [31:0]  dbg_b;
    logic [15:0]  busy_b;

    logic [127:0] rs_data_c;
    logic [3:0]   stall_c;
    logic [31:0]  dbg_c;
    logic [15:0]  busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_file #(.WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rs_addr({ra1, ra0}), .rs_data(rs_data_a),
        .rs_stall(stall_a), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_vld(issue_vld), .issue_rd(issue_rd), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_a), .busy_vec(busy_a)
    );

    pipe_reg_file #(.WIDTH(32), .NUM_REGS(16), .NUM_READ(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rs_addr(ra0[3:0]), .rs_data(rs_data_b),
        .rs_stall(stall_b), .we(we), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
        .issue_vld(issue_vld), .issue_rd(issue_rd[3:0]), .flush(flush),
        .dbg_addr(dbg_addr[3:0]), .dbg_data(dbg_b), .busy_vec(busy_b)
    );

    pipe_reg_file #(.WIDTH(32), .NUM_REGS(16), .NUM_READ(4), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset),
        .rs_addr({ra1[3:0], ra0[3:0], ra1[3:0], ra0[3:0]}), .rs_data(rs_data_c),
        .rs_stall(stall_c), .we(we), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
        .issue_vld(issue_vld), .issue_rd(issue_rd[3:0]), .flush(flush),
        .dbg_addr(dbg_addr[3:0]), .dbg_data(dbg_c), .busy_vec(busy_c)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        we        = 1'b0;
        issue_vld = 1'b0;
        flush     = 1'b0;
    endtask

    // Reset with a write attempted inside it; everything must read back zero.
    task automatic test_reset();
        reset = 1'b1; idle(); flush = 1'b0;
        wr_addr = 5'd5; wr_data = 32'd7; we = 1'b1;
        issue_rd = 5'd0; dbg_addr = 5'd0; ra0 = 5'd5; ra1 = 5'd6;
        tick(); tick();
        reset = 1'b0; idle();
        #1;
        checks++; if (busy_a !== 32'h0) begin errors++; $display("FAIL reset_busy_a got %h want 0", busy_a); end
        checks++; if (busy_b !== 16'h0) begin errors++; $display("FAIL reset_busy_b got %h want 0", busy_b); end
        checks++; if (busy_c !== 16'h0) begin errors++; $display("FAIL reset_busy_c got %h want 0", busy_c); end
        checks++; if (rs_data_a !== 64'h0) begin errors++; $display("FAIL reset_rs_a got %h want 0", rs_data_a); end
        checks++; if (rs_data_c !== 128'h0) begin errors++; $display("FAIL reset_rs_c got %h want 0", rs_data_c); end
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL reset_stall_a got %b want 00", stall_a); end
        for (int k = 0; k < 32; k++) begin
            dbg_addr = 5'(k);
            #1;
            checks++; if (dbg_a !== 32'h0) begin errors++; $display("FAIL reset_dbg_a[%0d] got %h want 0", k, dbg_a); end
            if (k < 16) begin
                checks++; if (dbg_b !== 32'h0) begin errors++; $display("FAIL reset_dbg_b[%0d] got %h want 0", k, dbg_b); end
                checks++; if (dbg_c !== 32'h0) begin errors++; $display("FAIL reset_dbg_c[%0d] got %h want 0", k, dbg_c); end
            end
        end
    endtask

    // Consecutive writes, array visibility next cycle, same-cycle bypass vs no bypass.
    task automatic test_write();
        tick();
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'd10; ra0 = 5'd6; ra1 = 5'd5;
        #1;
        checks++; if (rs_data_a[63:32] !== 32'd10) begin errors++; $display("FAIL wr_bypass_a5 got %h want a", rs_data_a[63:32]); end
        tick();
        wr_addr = 5'd6; wr_data = 32'd5; dbg_addr = 5'd5;
        #1;
        checks++; if (dbg_a !== 32'd10) begin errors++; $display("FAIL wr_dbg_a5 got %h want a", dbg_a); end
        checks++; if (dbg_b !== 32'd10) begin errors++; $display("FAIL wr_dbg_b5 got %h want a", dbg_b); end
        checks++; if (rs_data_a[31:0] !== 32'd5) begin errors++; $display("FAIL wr_bypass_a6 got %h want 5", rs_data_a[31:0]); end
        checks++; if (rs_data_b !== 32'd0) begin errors++; $display("FAIL wr_nobypass_b6 got %h want 0", rs_data_b); end
        checks++; if (rs_data_c !== {32'd10, 32'd5, 32'd10, 32'd5}) begin errors++; $display("FAIL wr_ports_c got %h want a/5 pattern", rs_data_c); end
        tick();
        idle(); dbg_addr = 5'd6;
        #1;
        checks++; if (dbg_a !== 32'd5) begin errors++; $display("FAIL wr_dbg_a6 got %h want 5", dbg_a); end
        checks++; if (dbg_b !== 32'd5) begin errors++; $display("FAIL wr_dbg_b6 got %h want 5", dbg_b); end
        checks++; if (rs_data_b !== 32'd5) begin errors++; $display("FAIL wr_array_b6 got %h want 5", rs_data_b); end
    endtask

    // Register 0: writes dropped, never busy, reads zero, no stall.
    task automatic test_zero();
        tick();
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD;
        issue_vld = 1'b1; issue_rd = 5'd0; ra0 = 5'd0; ra1 = 5'd0;
        #1;
        checks++; if (rs_data_a !== 64'h0) begin errors++; $display("FAIL zero_rs_a got %h want 0", rs_data_a); end
        checks++; if (rs_data_c !== 128'h0) begin errors++; $display("FAIL zero_rs_c got %h want 0", rs_data_c); end
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL zero_stall_a got %b want 00", stall_a); end
        tick();
        idle(); dbg_addr = 5'd0;
        #1;
        checks++; if (dbg_a !== 32'h0) begin errors++; $display("FAIL zero_dbg_a got %h want 0", dbg_a); end
        checks++; if (busy_a !== 32'h0) begin errors++; $display("FAIL zero_busy_a got %h want 0", busy_a); end
        checks++; if (busy_b !== 16'h0) begin errors++; $display("FAIL zero_busy_b got %h want 0", busy_b); end
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL zero_stall_a2 got %b want 00", stall_a); end
    endtask

    // Issue rd=7, stall until writeback, bypass drops the stall in the writeback cycle.
    task automatic test_busy();
        tick();
        issue_vld = 1'b1; issue_rd = 5'd7; ra0 = 5'd7; ra1 = 5'd7;
        #1;
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL busy_prestall_a got %b want 00", stall_a); end
        tick();
        idle();
        #1;
        checks++; if (busy_a !== 32'h80) begin errors++; $display("FAIL busy_set_a got %h want 80", busy_a); end
        checks++; if (busy_b !== 16'h80) begin errors++; $display("FAIL busy_set_b got %h want 80", busy_b); end
        checks++; if (stall_a !== 2'b11) begin errors++; $display("FAIL busy_stall_a got %b want 11", stall_a); end
        checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL busy_stall_b got %b want 1", stall_b); end
        checks++; if (stall_c !== 4'hf) begin errors++; $display("FAIL busy_stall_c got %b want 1111", stall_c); end
        tick();
        #1;
        checks++; if (stall_a !== 2'b11) begin errors++; $display("FAIL busy_hold_a got %b want 11", stall_a); end
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
        #1;
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL busy_wb_stall_a got %b want 00", stall_a); end
        checks++; if (rs_data_a !== {32'd42, 32'd42}) begin errors++; $display("FAIL busy_wb_rs_a got %h want 2a/2a", rs_data_a); end
        checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL busy_wb_stall_b got %b want 1", stall_b); end
        checks++; if (rs_data_b !== 32'd0) begin errors++; $display("FAIL busy_wb_rs_b got %h want 0", rs_data_b); end
        checks++; if (stall_c !== 4'h0) begin errors++; $display("FAIL busy_wb_stall_c got %b want 0000", stall_c); end
        checks++; if (busy_a !== 32'h80) begin errors++; $display("FAIL busy_wb_busy_a got %h want 80", busy_a); end
        tick();
        idle();
        #1;
        checks++; if (busy_a !== 32'h0) begin errors++; $display("FAIL busy_clr_a got %h want 0", busy_a); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL busy_clr_stall_b got %b want 0", stall_b); end
        checks++; if (rs_data_b !== 32'd42) begin errors++; $display("FAIL busy_clr_rs_b got %h want 2a", rs_data_b); end
    endtask

    // Set/clear collision, flush with issue, and a write with no busy bit.
    task automatic test_back_to_back();
        tick();
        issue_vld = 1'b1; issue_rd = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 32'd99;
        tick();
        we = 1'b0; issue_rd = 5'd5;
        #1;
        checks++; if (busy_a !== 32'h200) begin errors++; $display("FAIL b2b_setwins_a got %h want 200", busy_a); end
        checks++; if (busy_b !== 16'h200) begin errors++; $display("FAIL b2b_setwins_b got %h want 200", busy_b); end
        tick();
        flush = 1'b1; issue_rd = 5'd3;
        #1;
        checks++; if (busy_a !== 32'h220) begin errors++; $display("FAIL b2b_two_busy_a got %h want 220", busy_a); end
        tick();
        idle();
        #1;
        checks++; if (busy_a !== 32'h8) begin errors++; $display("FAIL b2b_flush_a got %h want 8", busy_a); end
        checks++; if (busy_b !== 16'h8) begin errors++; $display("FAIL b2b_flush_b got %h want 8", busy_b); end
        checks++; if (busy_c !== 16'h8) begin errors++; $display("FAIL b2b_flush_c got %h want 8", busy_c); end
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'd123;
        tick();
        idle(); dbg_addr = 5'd9;
        #1;
        checks++; if (dbg_a !== 32'd123) begin errors++; $display("FAIL b2b_orphan_wr_a got %h want 7b", dbg_a); end
        checks++; if (dbg_b !== 32'd123) begin errors++; $display("FAIL b2b_orphan_wr_b got %h want 7b", dbg_b); end
        checks++; if (busy_a !== 32'h8) begin errors++; $display("FAIL b2b_orphan_busy_a got %h want 8", busy_a); end
    endtask

    // Reset asserted between edges clears everything at once; first edge after release is normal.
    task automatic test_async_reset();
        tick();
        ra0 = 5'd3; ra1 = 5'd6; dbg_addr = 5'd9;
        #1;
        checks++; if (stall_a !== 2'b01) begin errors++; $display("FAIL ar_pre_stall_a got %b want 01", stall_a); end
        checks++; if (rs_data_a[63:32] !== 32'd5) begin errors++; $display("FAIL ar_pre_rs_a got %h want 5", rs_data_a[63:32]); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy_a !== 32'h0) begin errors++; $display("FAIL ar_busy_a got %h want 0", busy_a); end
        checks++; if (busy_b !== 16'h0) begin errors++; $display("FAIL ar_busy_b got %h want 0", busy_b); end
        checks++; if (stall_a !== 2'b00) begin errors++; $display("FAIL ar_stall_a got %b want 00", stall_a); end
        checks++; if (rs_data_a !== 64'h0) begin errors++; $display("FAIL ar_rs_a got %h want 0", rs_data_a); end
        checks++; if (dbg_a !== 32'h0) begin errors++; $display("FAIL ar_dbg_a got %h want 0", dbg_a); end
        checks++; if (dbg_b !== 32'h0) begin errors++; $display("FAIL ar_dbg_b got %h want 0", dbg_b); end
        tick();
        reset = 1'b0;
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'd44; issue_vld = 1'b1; issue_rd = 5'd2;
        tick();
        idle(); dbg_addr = 5'd4;
        #1;
        checks++; if (dbg_a !== 32'd44) begin errors++; $display("FAIL ar_post_wr_a got %h want 2c", dbg_a); end
        checks++; if (dbg_c !== 32'd44) begin errors++; $display("FAIL ar_post_wr_c got %h want 2c", dbg_c); end
        checks++; if (busy_a !== 32'h4) begin errors++; $display("FAIL ar_post_busy_a got %h want 4", busy_a); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero();
        test_busy();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
